fc_frame_stack: RTL and testbench

//   LIFO of saved register-file frames for call/return. On push, captures the
//   240-bit frame context (15 x 16-bit registers) driven out of the register

---
 rtl/fc_frame_stack.sv | 149 ++++++++++++++
 tb/tb_fc_frame_stack.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_frame_stack.sv
// rtl/fc_frame_stack.sv - LIFO of saved register-file frames for call/return
module fc_frame_stack #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 15,
  parameter  int DEPTH = 8,
  localparam int FW    = WIDTH * NREGS,
  localparam int SPW   = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           clear_err,
  input  logic [FW-1:0]  fc_in,
  output logic [FW-1:0]  fc_out,
  output logic           restore,
  output logic           busy,
  output logic [SPW-1:0] sp,
  output logic           empty,
  output logic           full,
  output logic           overflow,
  output logic           underflow,
  output logic           proto_err
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [FW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_m1;
  logic           do_push;
  logic           do_pop;
  logic           ovf_evt;
  logic           udf_evt;
  logic           proto_evt;

  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));
  assign sp_m1 = sp - 1'b1;

  // Strobes decode straight from the state register, so no input can reach them.
  assign restore = (state == ST_RESTORE);
  assign busy    = (state == ST_RESTORE);

  // State register; reset aborts any restore in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and command decode; push has priority over a same-cycle pop.
  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    proto_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (push) begin
          if (full) begin
            ovf_evt = 1'b1;
          end else begin
            do_push = 1'b1;
          end
          if (pop) begin
            proto_evt = 1'b1;
          end
        end else if (pop) begin
          if (empty) begin
            udf_evt = 1'b1;
          end else begin
            do_pop    = 1'b1;
            state_nxt = ST_RESTORE;
          end
        end
      end
      ST_RESTORE: begin
        proto_evt = push | pop;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stack pointer moves only on accepted commands, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp <= sp_m1;
    end
  end

  // Frame storage is left unreset; only slots below sp are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp[AW-1:0]] <= fc_in;
    end
  end

  // Popped frame is held for the register file until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_out <= '0;
    end else if (do_pop) begin
      fc_out <= mem[sp_m1[AW-1:0]];
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (udf_evt) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
      if (proto_evt) begin
        proto_err <= 1'b1;
      end else if (clear_err) begin
        proto_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_frame_stack.sv
// tb/tb_fc_frame_stack.sv - directed-vector bench for fc_frame_stack
module tb_fc_frame_stack;

  localparam int WIDTH = 16;
  localparam int NREGS = 15;
  localparam int DEPTH = 8;
  localparam int FW    = WIDTH * NREGS;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           push, pop, clear_err;
  logic [FW-1:0]  fc_drv;
  logic [FW-1:0]  fc_in;
  logic [FW-1:0]  fc_out;
  logic           restore, busy, empty, full, overflow, underflow, proto_err;
  logic [SPW-1:0] sp;

  int vectors    = 0;
  int miscompares = 0;

  // Register file model: 64 x 16, r1..r15 form the frame context.
  logic [15:0]   rf [64];
  logic          rf_we;
  logic [5:0]    rf_waddr;
  logic [15:0]   rf_wdata;
  logic [FW-1:0] rf_fc;
  logic          sel_rf;

  always #5 clk = ~clk;

  fc_frame_stack #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear_err (clear_err),
    .fc_in     (fc_in),
    .fc_out    (fc_out),
    .restore   (restore),
    .busy      (busy),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .proto_err (proto_err)
  );

  always_comb begin
    rf_fc = '0;
    for (int i = 0; i < NREGS; i++) rf_fc[16*i +: 16] = rf[i+1];
  end

  assign fc_in = sel_rf ? rf_fc : fc_drv;

  always @(posedge clk) begin
    if (restore) begin
      for (int i = 0; i < NREGS; i++) rf[i+1] <= fc_out[16*i +: 16];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  function automatic logic [FW-1:0] rep(input logic [15:0] v);
    return {NREGS{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; fc_drv = '0;
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({sp, empty, full, restore, busy} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ctrl: sp=%0d empty=%b full=%b restore=%b busy=%b, want 0 1 0 0 0",
               sp, empty, full, restore, busy);
    end
    vectors++;
    if ({overflow, underflow, proto_err} !== 3'b000 || fc_out !== '0) begin
      miscompares++;
      $display("FAIL reset_flags: ovf=%b udf=%b proto=%b fc_out_nz=%b, want 000 0",
               overflow, underflow, proto_err, |fc_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_push_pop();
    do_reset();
    push = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      fc_drv = rep(16'(i));
      tick();
    end
    push = 1'b0;
    vectors++;
    if (sp !== 4'd3) begin
      miscompares++; $display("FAIL push3_sp: got %0d want 3", sp);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    vectors++;
    if (fc_out !== rep(16'h0003) || restore !== 1'b1 || busy !== 1'b1 || sp !== 4'd2) begin
      miscompares++;
      $display("FAIL pop_restore: fc_out[15:0]=%h restore=%b busy=%b sp=%0d, want 0003 1 1 2",
               fc_out[15:0], restore, busy, sp);
    end
    tick();
    vectors++;
    if (restore !== 1'b0 || busy !== 1'b0 || fc_out !== rep(16'h0003)) begin
      miscompares++;
      $display("FAIL restore_width: restore=%b busy=%b fc_out[15:0]=%h, want 0 0 0003",
               restore, busy, fc_out[15:0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      fc_drv = rep(16'h0100 + 16'(i));
      tick();
    end
    vectors++;
    if (full !== 1'b1 || sp !== 4'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill: full=%b sp=%0d ovf=%b, want 1 8 0", full, sp, overflow);
    end
    fc_drv = rep(16'hdead);
    tick();
    push = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || sp !== 4'd8) begin
      miscompares++;
      $display("FAIL overflow: ovf=%b sp=%0d, want 1 8", overflow, sp);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    vectors++;
    if (fc_out !== rep(16'h0108) || sp !== 4'd7) begin
      miscompares++;
      $display("FAIL pop_top: fc_out[15:0]=%h sp=%0d, want 0108 7", fc_out[15:0], sp);
    end
    tick();
  endtask

  task automatic test_underflow();
    do_reset();
    pop = 1'b1;
    tick();
    vectors++;
    if (underflow !== 1'b1 || sp !== 4'd0 || restore !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow: udf=%b sp=%0d restore=%b busy=%b, want 1 0 0 0",
               underflow, sp, restore, busy);
    end
    clear_err = 1'b1;
    tick();
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++; $display("FAIL clear_priority: udf=%b want 1", underflow);
    end
    pop = 1'b0;
    tick();
    clear_err = 1'b0;
    vectors++;
    if (underflow !== 1'b0 || restore !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_err: udf=%b restore=%b, want 0 0", underflow, restore);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    push = 1'b1;
    fc_drv = rep(16'h00a1); tick();
    fc_drv = rep(16'h00a2); tick();
    fc_drv = rep(16'h00a3);
    pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    vectors++;
    if (sp !== 4'd3 || proto_err !== 1'b1 || restore !== 1'b0) begin
      miscompares++;
      $display("FAIL push_pop_same: sp=%0d proto=%b restore=%b, want 3 1 0",
               sp, proto_err, restore);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++; $display("FAIL proto_clear: proto=%b want 0", proto_err);
    end
    pop = 1'b1;
    tick();
    vectors++;
    if (fc_out !== rep(16'h00a3) || restore !== 1'b1 || sp !== 4'd2) begin
      miscompares++;
      $display("FAIL pop_after_pp: fc_out[15:0]=%h restore=%b sp=%0d, want 00a3 1 2",
               fc_out[15:0], restore, sp);
    end
    tick();
    pop = 1'b0;
    vectors++;
    if (sp !== 4'd2 || proto_err !== 1'b1 || restore !== 1'b0 || fc_out !== rep(16'h00a3)) begin
      miscompares++;
      $display("FAIL pop_in_restore: sp=%0d proto=%b restore=%b fc_out[15:0]=%h, want 2 1 0 00a3",
               sp, proto_err, restore, fc_out[15:0]);
    end
    push = 1'b1;
    fc_drv = rep(16'h00b4);
    tick();
    push = 1'b0;
    vectors++;
    if (sp !== 4'd3) begin
      miscompares++; $display("FAIL push_after_restore: sp=%0d want 3", sp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push = 1'b1; fc_drv = rep(16'h0055); tick();
    push = 1'b0;
    pop = 1'b1; tick();
    pop = 1'b0;
    vectors++;
    if (restore !== 1'b1 || fc_out !== rep(16'h0055)) begin
      miscompares++;
      $display("FAIL pre_reset_restore: restore=%b fc_out[15:0]=%h, want 1 0055",
               restore, fc_out[15:0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (restore !== 1'b0 || busy !== 1'b0 || sp !== 4'd0 || fc_out !== '0) begin
      miscompares++;
      $display("FAIL async_reset: restore=%b busy=%b sp=%0d fc_out_nz=%b, want 0 0 0 0",
               restore, busy, sp, |fc_out);
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_regfile();
    do_reset();
    sel_rf = 1'b1;
    rf_we = 1'b1;
    for (int i = 1; i <= NREGS; i++) begin
      rf_waddr = 6'(i); rf_wdata = 16'ha000 + 16'(i);
      tick();
    end
    rf_we = 1'b0;
    push = 1'b1; tick(); push = 1'b0;
    rf_we = 1'b1;
    for (int i = 1; i <= NREGS; i++) begin
      rf_waddr = 6'(i); rf_wdata = 16'h5000 + 16'(i);
      tick();
    end
    rf_we = 1'b0;
    vectors++;
    if (rf[7] !== 16'h5007) begin
      miscompares++; $display("FAIL rf_overwrite: r7=%h want 5007", rf[7]);
    end
    pop = 1'b1; tick(); pop = 1'b0;
    tick();
    for (int i = 1; i <= NREGS; i++) begin
      vectors++;
      if (rf[i] !== 16'ha000 + 16'(i)) begin
        miscompares++;
        $display("FAIL rf_restore_r%0d: got %h want %h", i, rf[i], 16'ha000 + 16'(i));
      end
    end
    sel_rf = 1'b0;
  endtask

  initial begin
    sel_rf = 1'b0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    for (int i = 0; i < 64; i++) rf[i] = '0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_protocol();
    test_async_reset();
    test_regfile();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
